// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter feeding the register file's single write port.
// The ALU path has fixed priority; LSU results are buffered in a DEPTH-entry
// FIFO whose entries carry a live bit so that younger ALU writes can squash them.
// Optional feature macro: WB_ARB_BYPASS_EN (LSU result skips an empty FIFO).
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_waddr,
    input  logic [DW-1:0]            alu_wdata,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [AW-1:0]            lsu_waddr,
    input  logic [DW-1:0]            lsu_wdata,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    input  logic [AW-1:0]            pend_raddr1,
    input  logic [AW-1:0]            pend_raddr2,
    output logic                     pend_hit1,
    output logic                     pend_hit2,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addrMem [DEPTH];
    logic [DW-1:0]    dataMem [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rfWe_q, rfWe_d;
    logic [AW-1:0]    rfWaddr_q, rfWaddr_d;
    logic [DW-1:0]    rfWdata_q, rfWdata_d;

    logic aluIssue;
    logic lsuAccept;
    logic headValid;
    logic headLive;
    logic headDead;
    logic liveIssue;
    logic pop;
    logic bypass;
    logic pushEnq;
    logic pushSquashed;

    // Ready comes only from the registered count, so a pop never ripples into ready.
    assign lsu_ready    = (count_q < CW'(DEPTH));

    // Writes to register 0 are architecturally void and are dropped at the door.
    assign aluIssue     = alu_valid && (alu_waddr != '0);
    assign lsuAccept    = lsu_valid && lsu_ready && (lsu_waddr != '0);

    assign headValid    = (count_q != '0);
    assign headLive     = headValid && live_q[rdPtr_q];
    assign headDead     = headValid && !live_q[rdPtr_q];
    assign liveIssue    = headLive && !aluIssue;
    // A squashed head is discarded even while the ALU owns the write port.
    assign pop          = headDead || liveIssue;

`ifdef WB_ARB_BYPASS_EN
    assign bypass       = lsuAccept && !aluIssue && !headValid;
`else
    assign bypass       = 1'b0;
`endif

    assign pushEnq      = lsuAccept && !bypass;
    // The ALU result is program-younger than anything arriving from the LSU.
    assign pushSquashed = aluIssue && (lsu_waddr == alu_waddr);

    // Next-state for live bits: squash matches, retire the popped slot, mark the new slot.
    always_comb begin
        live_d = live_q;
        if (aluIssue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addrMem[i] == alu_waddr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rdPtr_q] = 1'b0;
        end
        if (pushEnq) begin
            live_d[wrPtr_q] = !pushSquashed;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_comb begin
        rdPtr_d = pop     ? rdPtr_q + PW'(1) : rdPtr_q;
        wrPtr_d = pushEnq ? wrPtr_q + PW'(1) : wrPtr_q;
        count_d = count_q + CW'(pushEnq) - CW'(pop);
    end

    // Write-port selection: ALU first, then a live FIFO head, then an optional bypass.
    always_comb begin
        rfWe_d    = 1'b0;
        rfWaddr_d = rfWaddr_q;
        rfWdata_d = rfWdata_q;
        if (aluIssue) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = alu_waddr;
            rfWdata_d = alu_wdata;
        end else if (liveIssue) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = addrMem[rdPtr_q];
            rfWdata_d = dataMem[rdPtr_q];
        end else if (bypass) begin
            rfWe_d    = 1'b1;
            rfWaddr_d = lsu_waddr;
            rfWdata_d = lsu_wdata;
        end
    end

    // FIFO payload storage; stale contents are harmless because live bits gate them.
    always_ff @(posedge clk) begin
        if (pushEnq) begin
            addrMem[wrPtr_q] <= lsu_waddr;
            dataMem[wrPtr_q] <= lsu_wdata;
        end
    end

    // Control state with synchronous reset; reset discards everything outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q    <= '0;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
            rfWe_q    <= 1'b0;
            rfWaddr_q <= '0;
            rfWdata_q <= '0;
        end else begin
            live_q    <= live_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
            rfWe_q    <= rfWe_d;
            rfWaddr_q <= rfWaddr_d;
            rfWdata_q <= rfWdata_d;
        end
    end

    // Pending-write lookup for the decode interlock: queued live entries or the write in flight.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addrMem[i] == pend_raddr1)) begin
                pend_hit1 = 1'b1;
            end
            if (live_q[i] && (addrMem[i] == pend_raddr2)) begin
                pend_hit2 = 1'b1;
            end
        end
        if (rfWe_q && (rfWaddr_q == pend_raddr1)) begin
            pend_hit1 = 1'b1;
        end
        if (rfWe_q && (rfWaddr_q == pend_raddr2)) begin
            pend_hit2 = 1'b1;
        end
        if (pend_raddr1 == '0) begin
            pend_hit1 = 1'b0;
        end
        if (pend_raddr2 == '0) begin
            pend_hit2 = 1'b0;
        end
    end

    assign rf_we      = rfWe_q;
    assign rf_waddr   = rfWaddr_q;
    assign rf_wdata   = rfWdata_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter. A queue-based reference model
// predicts every register-file write; a monitor matches them against rf_* as they appear.
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic                   alu_valid;
    logic [AW-1:0]          alu_waddr;
    logic [DW-1:0]          alu_wdata;
    logic                   lsu_valid;
    logic                   lsu_ready;
    logic [AW-1:0]          lsu_waddr;
    logic [DW-1:0]          lsu_wdata;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DW-1:0]          rf_wdata;
    logic [AW-1:0]          pend_raddr1;
    logic [AW-1:0]          pend_raddr2;
    logic                   pend_hit1;
    logic                   pend_hit2;
    logic [$clog2(DEPTH):0] fifo_count;

    wb_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_raddr1(pend_raddr1), .pend_raddr2(pend_raddr2),
        .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .fifo_count(fifo_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            live;
    } entry_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    entry_t        mq[$];
    wr_t           expQ[$];
    bit            mRfWe;
    logic [AW-1:0] mRfAddr;
    int            cyc;
    int            nChecks;
    int            nFails;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time-stamp expected writes.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit modelPend(input logic [AW-1:0] a);
        if (a == '0) return 1'b0;
        if (mRfWe && mRfAddr == a) return 1'b1;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].addr == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [AW-1:0] pickAddr();
        if (mq.size() > 0 && $urandom_range(0, 1) == 0)
            return mq[$urandom_range(0, mq.size() - 1)].addr;
        if (mRfWe && $urandom_range(0, 2) == 0)
            return mRfAddr;
        return AW'($urandom_range(0, 31));
    endfunction

    function automatic void expectWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = cyc + 1;
        expQ.push_back(w);
        mRfWe   = 1'b1;
        mRfAddr = a;
    endfunction

    task automatic checkPend(input string name, input logic [AW-1:0] a, input bit exp);
        pend_raddr1 = a;
        pend_raddr2 = a;
        #1;
        checkOutput({name, "_hit1"}, 64'(pend_hit1), 64'(exp));
        checkOutput({name, "_hit2"}, 64'(pend_hit2), 64'(exp));
    endtask

    // Called at a negedge: checks live outputs, drives one cycle, advances the model.
    task automatic applyStimulus(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                 input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                                 output bit acc);
        bit aluIss;
        bit wrote;
        int sizeBefore;
        entry_t e;
        pend_raddr1 = pickAddr();
        pend_raddr2 = pickAddr();
        #1;
        checkOutput("pend_hit1", 64'(pend_hit1), 64'(modelPend(pend_raddr1)));
        checkOutput("pend_hit2", 64'(pend_hit2), 64'(modelPend(pend_raddr2)));
        checkOutput("fifo_count", 64'(fifo_count), 64'(mq.size()));
        checkOutput("lsu_ready", 64'(lsu_ready), 64'(mq.size() < DEPTH));

        alu_valid = av;
        alu_waddr = aa;
        alu_wdata = ad;
        lsu_valid = lv;
        lsu_waddr = la;
        lsu_wdata = ld;

        aluIss     = av && (aa != '0);
        sizeBefore = mq.size();
        acc        = lv && (sizeBefore < DEPTH);
        wrote      = 1'b0;
        if (aluIss) begin
            expectWrite(aa, ad);
            wrote = 1'b1;
        end
        if (sizeBefore > 0) begin
            if (!mq[0].live) begin
                void'(mq.pop_front());
            end else if (!aluIss) begin
                e = mq.pop_front();
                expectWrite(e.addr, e.data);
                wrote = 1'b1;
            end
        end
        if (aluIss) begin
            foreach (mq[i]) begin
                if (mq[i].addr == aa) mq[i].live = 1'b0;
            end
        end
        if (acc && la != '0) begin
            if (BYP && sizeBefore == 0 && !aluIss) begin
                expectWrite(la, ld);
                wrote = 1'b1;
            end else begin
                e.addr = la;
                e.data = ld;
                e.live = !(aluIss && la == aa);
                mq.push_back(e);
            end
        end
        if (!wrote) mRfWe = 1'b0;

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, acc);
    endtask

    // One-cycle reset pulse, optionally with traffic on the inputs that must be discarded.
    task automatic applyReset(input bit withTraffic);
        reset     = 1'b1;
        alu_valid = withTraffic;
        alu_waddr = 5'd9;
        alu_wdata = 32'hDEAD0009;
        lsu_valid = withTraffic;
        lsu_waddr = 5'd6;
        lsu_wdata = 32'hDEAD0006;
        @(posedge clk);
        mq.delete();
        mRfWe = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        checkOutput("reset_rf_we", 64'(rf_we), 64'd0);
        checkOutput("reset_rf_waddr", 64'(rf_waddr), 64'd0);
        checkOutput("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        checkOutput("reset_fifo_count", 64'(fifo_count), 64'd0);
        checkOutput("reset_lsu_ready", 64'(lsu_ready), 64'd1);
    endtask

    // Scoreboard monitor: every rf write must match the oldest expected write and its cycle.
    always @(negedge clk) begin
        wr_t w;
        if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            w = expQ.pop_front();
            checkOutput("missed_write_cycle", 64'(cyc), 64'(w.cyc));
        end
        if (rf_we) begin
            checkOutput("rf_waddr_nonzero", 64'(rf_waddr == '0), 64'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rf_we", 64'(rf_we), 64'd0);
            end else begin
                w = expQ.pop_front();
                checkOutput("write_cycle", 64'(cyc), 64'(w.cyc));
                checkOutput("write_addr", 64'(rf_waddr), 64'(w.addr));
                checkOutput("write_data", 64'(rf_wdata), 64'(w.data));
            end
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        bit            acc;
        bit            offer;
        bit            av;
        logic [AW-1:0] aa;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        int            a;
        int            tries;

        nChecks     = 0;
        nFails      = 0;
        mRfWe       = 1'b0;
        mRfAddr     = '0;
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_waddr   = '0;
        alu_wdata   = '0;
        lsu_valid   = 1'b0;
        lsu_waddr   = '0;
        lsu_wdata   = '0;
        pend_raddr1 = '0;
        pend_raddr2 = '0;
        @(negedge clk);
        applyReset(1'b0);

        // Single ALU write with one-cycle latency.
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, acc);
        checkOutput("t1_rf_we", 64'(rf_we), 64'd1);
        checkOutput("t1_rf_waddr", 64'(rf_waddr), 64'd5);
        checkOutput("t1_rf_wdata", 64'(rf_wdata), 64'h1234);
        idle(1);
        checkOutput("t1_rf_we_after", 64'(rf_we), 64'd0);
        idle(1);

        // Continuous ALU writes starve the FIFO until it fills.
        a = 0;
        for (int k = 8; k < 12; k++) begin
            applyStimulus(1'b1, AW'((a % 7) + 1), $urandom, 1'b1, AW'(k), 32'h100 + k, acc);
            a++;
            checkOutput("t2_accept", 64'(acc), 64'd1);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, AW'((a % 7) + 1), $urandom, 1'b1, 5'd12, 32'h10C, acc);
            a++;
            checkOutput("t2_full_count", 64'(fifo_count), 64'd4);
            checkOutput("t2_full_ready", 64'(lsu_ready), 64'd0);
        end
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 12) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 5'd12, 32'h10C, acc);
            tries++;
        end
        checkOutput("t2_accept_12", 64'(acc), 64'd1);
        idle(8);

        // ALU write squashes an older queued load to the same register.
        applyReset(1'b0);
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hAAAA, acc);
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b0, '0, '0, acc);
        checkPend("t3_pend_queued", 5'd7, 1'b1);
        applyStimulus(1'b1, 5'd7, 32'hBBBB, 1'b0, '0, '0, acc);
        checkPend("t3_pend_inflight", 5'd7, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, acc);
        checkPend("t3_pend_cleared", 5'd7, 1'b0);
        checkOutput("t3_dead_pop_we", 64'(rf_we), 64'd0);
        checkOutput("t3_dead_pop_count", 64'(fifo_count), 64'd0);
        idle(2);

        // Register 0 traffic is accepted but produces nothing.
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE, acc);
        checkOutput("t4_rf_we", 64'(rf_we), 64'd0);
        checkOutput("t4_count", 64'(fifo_count), 64'd0);
        checkOutput("t4_ready", 64'(lsu_ready), 64'd1);
        idle(2);

        // Reset in the middle of a drain wipes the queue and interlock.
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0, acc);
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hA1, acc);
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hA2, acc);
        applyStimulus(1'b1, 5'd4, 32'h4, 1'b1, 5'd13, 32'hA3, acc);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, acc);
        applyReset(1'b1);
        for (int r = 0; r < 32; r++) checkPend("t5_pend", AW'(r), 1'b0);
        idle(3);

        // Empty FIFO, no ALU: direct issue with bypass, otherwise one cycle later.
        applyReset(1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'h55, acc);
        checkOutput("t6_rf_we_edge1", 64'(rf_we), 64'(BYP));
        checkOutput("t6_count_edge1", 64'(fifo_count), 64'(!BYP));
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, acc);
        checkOutput("t6_rf_we_edge2", 64'(rf_we), 64'(!BYP));
        checkOutput("t6_count_edge2", 64'(fifo_count), 64'd0);
        idle(2);

        // Randomized traffic; small address range forces squashes and register-0 cases.
        offer = 1'b0;
        oa    = '0;
        od    = '0;
        for (int n = 0; n < 400; n++) begin
            if (!offer && $urandom_range(0, 9) < 6) begin
                offer = 1'b1;
                oa    = AW'($urandom_range(0, 7));
                od    = $urandom;
            end
            av = ($urandom_range(0, 9) < 4);
            aa = AW'($urandom_range(0, 7));
            applyStimulus(av, aa, $urandom, offer, oa, od, acc);
            if (acc) offer = 1'b0;
            if (n == 200) begin
                applyReset(1'b1);
                offer = 1'b0;
            end
        end
        idle(10);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
